// File: rtl/lfsr_fib_leap.sv
// Fibonacci LFSR word source: OUT_BITS-step leap per accepted word, valid/ready output, zero-seed guard.
// Define LFSR_FIB_LEAP_COUNT_EN to build the accepted-word counter; otherwise word_count reads 0.
module lfsr_fib_leap #(
    parameter int               WIDTH        = 28,
    parameter logic [WIDTH-1:0] TAPS         = 28'h9000000,
    parameter int               OUT_BITS     = 4,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 'h1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                seed_load,
    input  logic [WIDTH-1:0]    seed,
    output logic [OUT_BITS-1:0] r,
    output logic                r_valid,
    input  logic                r_ready,
    output logic                lockup,
    output logic [31:0]         word_count
);

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     s_q, s_d;
    logic [OUT_BITS-1:0]  r_q, r_d;
    logic                 r_valid_q, r_valid_d;
    logic                 lockup_q, lockup_d;
    logic                 fire;

    // All OUT_BITS shifts are unrolled so a fresh word is ready every cycle.
    function automatic logic [WIDTH-1:0] leap(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] v;
        v = s;
        for (int i = 0; i < OUT_BITS; i++) begin
            v = {v[WIDTH-2:0], ^(v & TAPS)};
        end
        return v;
    endfunction

    assign fire = r_valid_q & r_ready;

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        r_d       = r_q;
        r_valid_d = r_valid_q;
        lockup_d  = 1'b0;
        // Reseed wins over everything, including a pending fire.
        if (seed_load) begin
            s_d       = (seed == '0) ? DEFAULT_SEED : seed;
            lockup_d  = (seed == '0);
            r_valid_d = 1'b0;
            state_d   = PRIME;
        end else begin
            case (state_q)
                PRIME: begin
                    r_d       = s_q[WIDTH-1 -: OUT_BITS];
                    s_d       = leap(s_q);
                    r_valid_d = 1'b1;
                    state_d   = RUN;
                end
                RUN: begin
                    if (fire) begin
                        r_d = s_q[WIDTH-1 -: OUT_BITS];
                        s_d = leap(s_q);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            s_q       <= '0;
            r_q       <= '0;
            r_valid_q <= 1'b0;
            lockup_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            r_q       <= r_d;
            r_valid_q <= r_valid_d;
            lockup_q  <= lockup_d;
        end
    end

    assign r       = r_q;
    assign r_valid = r_valid_q;
    assign lockup  = lockup_q;

`ifdef LFSR_FIB_LEAP_COUNT_EN
    logic [31:0] word_count_q, word_count_d;

    always_comb begin
        word_count_d = word_count_q;
        if (seed_load)  word_count_d = 32'h0;
        else if (fire)  word_count_d = word_count_q + 32'h1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) word_count_q <= 32'h0;
        else       word_count_q <= word_count_d;
    end

    assign word_count = word_count_q;
`else
    assign word_count = 32'h0;
`endif

endmodule

// File: tb/tb_lfsr_fib_leap.sv
// Bench for lfsr_fib_leap: known 4-bit sequences from a table, plus a randomized
// run of the default 28-bit configuration against a transaction-level model.
module tb_lfsr_fib_leap;

    logic        clk = 1'b0;
    logic        reset;
    logic        seed_load;
    logic        r_ready;
    logic [3:0]  seed4;
    logic [27:0] seed28;

    logic [0:0]  r_a;
    logic        r_valid_a, lockup_a;
    logic [31:0] wc_a;
    logic [3:0]  r_b;
    logic        r_valid_b, lockup_b;
    logic [31:0] wc_b;
    logic [3:0]  r_c;
    logic        r_valid_c, lockup_c;
    logic [31:0] wc_c;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lfsr_fib_leap #(.WIDTH(4), .TAPS(4'b1100), .OUT_BITS(1), .DEFAULT_SEED(4'h1)) dut_a (
        .clk(clk), .reset(reset), .seed_load(seed_load), .seed(seed4),
        .r(r_a), .r_valid(r_valid_a), .r_ready(r_ready), .lockup(lockup_a), .word_count(wc_a));

    lfsr_fib_leap #(.WIDTH(4), .TAPS(4'b1100), .OUT_BITS(4), .DEFAULT_SEED(4'h1)) dut_b (
        .clk(clk), .reset(reset), .seed_load(seed_load), .seed(seed4),
        .r(r_b), .r_valid(r_valid_b), .r_ready(r_ready), .lockup(lockup_b), .word_count(wc_b));

    lfsr_fib_leap dut_c (
        .clk(clk), .reset(reset), .seed_load(seed_load), .seed(seed28),
        .r(r_c), .r_valid(r_valid_c), .r_ready(r_ready), .lockup(lockup_c), .word_count(wc_c));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Known sequences for x^4+x^3+1 from seed 1: one bit per word and four bits per word.
    typedef struct packed {
        logic       r1;
        logic [3:0] r4;
    } vec_t;
    vec_t tbl [15];

    // Transaction-level model of the default instance: x^28+x^25+1, 4 bits per word.
    logic [27:0] m_s;
    logic [3:0]  m_r;
    logic        m_valid, m_prime, m_lock;
    logic [31:0] m_cnt;

    function automatic logic [27:0] advance(input logic [27:0] x, input int n);
        logic [27:0] y;
        logic        b;
        y = x;
        for (int k = 0; k < n; k++) begin
            b = y[27] ^ y[24];   // x^28 and x^25 terms
            y = (y << 1) | {27'd0, b};
        end
        return y;
    endfunction

    task automatic model_update(input logic ld, input logic [27:0] sd, input logic rdy);
        if (ld) begin
            m_s     = (sd == 28'd0) ? 28'd1 : sd;
            m_lock  = (sd == 28'd0);
            m_valid = 1'b0;
            m_prime = 1'b1;
            m_cnt   = 32'd0;
        end else begin
            m_lock = 1'b0;
            if (m_prime) begin
                m_r     = m_s[27:24];
                m_s     = advance(m_s, 4);
                m_valid = 1'b1;
                m_prime = 1'b0;
            end else if (m_valid && rdy) begin
                m_r = m_s[27:24];
                m_s = advance(m_s, 4);
`ifdef LFSR_FIB_LEAP_COUNT_EN
                m_cnt = m_cnt + 32'd1;
`endif
            end
        end
    endtask

    task automatic cyc(input string tag, input logic ld, input logic [27:0] sd, input logic rdy);
        seed_load = ld;
        seed28    = sd;
        r_ready   = rdy;
        model_update(ld, sd, rdy);
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        chk({tag, ".r_valid"}, r_valid_c, m_valid);
        chk({tag, ".lockup"}, lockup_c, m_lock);
        chk({tag, ".word_count"}, wc_c, m_cnt);
        if (m_valid) chk({tag, ".r"}, r_c, m_r);
    endtask

`ifdef LFSR_FIB_LEAP_COUNT_EN
    localparam logic [31:0] CNT7 = 32'd7;
`else
    localparam logic [31:0] CNT7 = 32'd0;
`endif

    initial begin
        logic [27:0] rs;
        logic        ld, rdy;

        tbl[0]  = '{1'b0, 4'h1}; tbl[1]  = '{1'b0, 4'h3}; tbl[2]  = '{1'b0, 4'h5};
        tbl[3]  = '{1'b1, 4'hE}; tbl[4]  = '{1'b0, 4'h2}; tbl[5]  = '{1'b0, 4'h6};
        tbl[6]  = '{1'b1, 4'hB}; tbl[7]  = '{1'b1, 4'hC}; tbl[8]  = '{1'b0, 4'h4};
        tbl[9]  = '{1'b1, 4'hD}; tbl[10] = '{1'b0, 4'h7}; tbl[11] = '{1'b1, 4'h8};
        tbl[12] = '{1'b1, 4'h9}; tbl[13] = '{1'b1, 4'hA}; tbl[14] = '{1'b1, 4'hF};

        reset = 1'b1; seed_load = 1'b0; r_ready = 1'b0; seed4 = 4'h0; seed28 = 28'h0;
        m_s = 28'd0; m_r = 4'd0; m_valid = 1'b0; m_prime = 1'b0; m_lock = 1'b0; m_cnt = 32'd0;
        #3;
        chk("reset.r", r_c, 4'h0);
        chk("reset.r_valid", r_valid_c, 1'b0);
        chk("reset.lockup", lockup_c, 1'b0);
        chk("reset.word_count", wc_c, 32'h0);
        chk("reset.r_valid_a", r_valid_a, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Known 4-bit sequences, latency and period.
        seed4 = 4'h1; seed_load = 1'b1; r_ready = 1'b1;
        @(posedge clk); #1;
        seed_load = 1'b0;
        chk("lat.r_valid_b_n1", r_valid_b, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("seq1[%0d]", i), r_a, tbl[i].r1);
            chk($sformatf("seq4[%0d]", i), r_b, tbl[i].r4);
            chk($sformatf("seq4v[%0d]", i), r_valid_b, 1'b1);
            @(posedge clk); #1;
        end
        chk("period.r1", r_a, tbl[0].r1);
        chk("period.r4", r_b, tbl[0].r4);

        // Zero seed on the small configuration falls back to DEFAULT_SEED=1.
        seed4 = 4'h0; seed_load = 1'b1;
        @(posedge clk); #1;
        seed_load = 1'b0;
        chk("zero4.lockup", lockup_b, 1'b1);
        chk("zero4.r_valid", r_valid_b, 1'b0);
        @(posedge clk); #1;
        chk("zero4.lockup_clr", lockup_b, 1'b0);
        chk("zero4.first", r_b, tbl[0].r4);
        seed4 = 4'h1;

        // Default configuration, zero seed: lockup pulse, first word 0, no stall.
        cyc("zero28", 1'b1, 28'h0, 1'b1);
        cyc("zero28.prime", 1'b0, 28'h0, 1'b1);
        chk("zero28.first_word", r_c, 4'h0);
        for (int i = 0; i < 20; i++) cyc("zero28.run", 1'b0, 28'h0, 1'b1);

        // Stall mid-stream, then resume.
        cyc("stall.load", 1'b1, 28'hACE1234, 1'b1);
        for (int i = 0; i < 4; i++) cyc("stall.pre", 1'b0, 28'h0, 1'b1);
        for (int i = 0; i < 5; i++) cyc("stall.hold", 1'b0, 28'h0, 1'b0);
        for (int i = 0; i < 4; i++) cyc("stall.post", 1'b0, 28'h0, 1'b1);

        // Reseed while a word is valid and the consumer is ready.
        cyc("reseed", 1'b1, 28'h1234567, 1'b1);
        chk("reseed.r_valid", r_valid_c, 1'b0);
        chk("reseed.count", wc_c, 32'h0);
        cyc("reseed.prime", 1'b0, 28'h0, 1'b1);
        for (int i = 0; i < 7; i++) cyc("count7", 1'b0, 28'h0, 1'b1);
        chk("count7.total", wc_c, CNT7);

        // Randomized traffic with occasional reseeds (some zero).
        for (int i = 0; i < 400; i++) begin
            ld  = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            rs  = 28'($urandom);
            if ($urandom_range(0, 3) == 0) rs = 28'h0;
            cyc("rand", ld, rs, rdy);
        end

        // Asynchronous reset between clock edges.
        cyc("prereset.load", 1'b1, 28'h0BADF00, 1'b1);
        for (int i = 0; i < 4; i++) cyc("prereset.run", 1'b0, 28'h0, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        chk("areset.r", r_c, 4'h0);
        chk("areset.r_valid", r_valid_c, 1'b0);
        chk("areset.word_count", wc_c, 32'h0);
        chk("areset.lockup", lockup_c, 1'b0);
        chk("areset.r_valid_b", r_valid_b, 1'b0);
        m_valid = 1'b0; m_prime = 1'b0; m_lock = 1'b0; m_cnt = 32'd0;
        #2;
        reset = 1'b0;
        @(posedge clk); #1;
        cyc("idle", 1'b0, 28'h0, 1'b1);
        cyc("idle", 1'b0, 28'h0, 1'b1);
        cyc("restart.load", 1'b1, 28'h7654321, 1'b1);
        for (int i = 0; i < 10; i++) cyc("restart.run", 1'b0, 28'h0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
